// File: rtl/cond_pkg.sv
// -----------------------------------------------------------------------------
// cond_pkg
// Shared definitions for the condition evaluation unit:
//   - the 16 four-bit condition code values (COND_EQ .. COND_NV)
//   - bit positions of the architectural flags inside a {Z,N,C,V} nibble
//   - the flags_t nibble type
//   - small helpers used when evaluating signed comparisons
// No ports (package).
// -----------------------------------------------------------------------------
package cond_pkg;

   // Architectural flag nibble, bit order {Z,N,C,V}
   typedef logic [3:0] flags_t;

   // Flag bit positions inside flags_t
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Condition codes
   localparam logic [3:0] COND_EQ = 4'd0;   // Z
   localparam logic [3:0] COND_NE = 4'd1;   // !Z
   localparam logic [3:0] COND_CS = 4'd2;   // C        (HS)
   localparam logic [3:0] COND_CC = 4'd3;   // !C       (LO)
   localparam logic [3:0] COND_MI = 4'd4;   // N
   localparam logic [3:0] COND_PL = 4'd5;   // !N
   localparam logic [3:0] COND_VS = 4'd6;   // V
   localparam logic [3:0] COND_VC = 4'd7;   // !V
   localparam logic [3:0] COND_HI = 4'd8;   // C & !Z
   localparam logic [3:0] COND_LS = 4'd9;   // !C | Z
   localparam logic [3:0] COND_GE = 4'd10;  // N == V
   localparam logic [3:0] COND_LT = 4'd11;  // N != V
   localparam logic [3:0] COND_GT = 4'd12;  // !Z & (N == V)
   localparam logic [3:0] COND_LE = 4'd13;  // Z | (N != V)
   localparam logic [3:0] COND_AL = 4'd14;  // always
   localparam logic [3:0] COND_NV = 4'd15;  // never (defined, never true)

   // Signed "greater or equal" term shared by GE/LT/GT/LE
   function automatic logic flags_n_eq_v(input flags_t f);
      return (f[FLAG_N] == f[FLAG_V]);
   endfunction

   // Unsigned "higher" term shared by HI/LS
   function automatic logic flags_hi(input flags_t f);
      return (f[FLAG_C] & ~f[FLAG_Z]);
   endfunction

endpackage : cond_pkg

// File: rtl/cond_lane.sv
// -----------------------------------------------------------------------------
// cond_lane
// Purely combinational evaluation of one 4-bit condition code against a
// {Z,N,C,V} flag nibble.
// Ports:
//   code   in  4  condition code (see cond_pkg COND_*)
//   flags  in  4  flags {Z,N,C,V} to test against
//   result out 1  1 when the condition holds
// -----------------------------------------------------------------------------
module cond_lane
   import cond_pkg::*;
(
   input  logic [3:0] code,
   input  flags_t     flags,
   output logic       result
);

   logic z_s;
   logic n_s;
   logic c_s;
   logic v_s;
   logic ge_s;
   logic hi_s;

   assign z_s  = flags[FLAG_Z];
   assign n_s  = flags[FLAG_N];
   assign c_s  = flags[FLAG_C];
   assign v_s  = flags[FLAG_V];
   assign ge_s = flags_n_eq_v(flags);
   assign hi_s = flags_hi(flags);

   // Condition table decode; NV is a defined code that never passes
   always_comb begin
      result = 1'b0;
      case (code)
         COND_EQ: result = z_s;
         COND_NE: result = ~z_s;
         COND_CS: result = c_s;
         COND_CC: result = ~c_s;
         COND_MI: result = n_s;
         COND_PL: result = ~n_s;
         COND_VS: result = v_s;
         COND_VC: result = ~v_s;
         COND_HI: result = hi_s;
         COND_LS: result = ~hi_s;
         COND_GE: result = ge_s;
         COND_LT: result = ~ge_s;
         COND_GT: result = ~z_s & ge_s;
         COND_LE: result = z_s | ~ge_s;
         COND_AL: result = 1'b1;
         COND_NV: result = 1'b0;
         default: result = 1'b0;
      endcase
   end

endmodule : cond_lane

// File: rtl/cond_eval_unit.sv
// -----------------------------------------------------------------------------
// cond_eval_unit
// Multi-lane condition evaluation unit owning the architectural Z N C V flag
// register and its shadow copy (exception entry/return). LANES condition codes
// are evaluated per accepted transaction and presented through a registered
// valid/ready output stage.
//
// Optional feature macro: COND_FLAG_BYPASS_EN
//   defined   : lanes evaluate against a same-cycle forward of the flag write
//               (restore > we > current flags), so an instruction accepted
//               together with its flag-setting write sees the new flags.
//   undefined : lanes evaluate against the registered flags only.
//
// Parameters:
//   LANES          number of condition codes per transaction (>= 1)
// Ports:
//   clk            in   1         rising-edge clock
//   rst_n          in   1         synchronous active-low reset
//   flags_we       in   1         load flags_wdata into the flag register
//   flags_wdata    in   4         new flags {Z,N,C,V}
//   flags_save     in   1         copy current flags into the shadow register
//   flags_restore  in   1         load flags from the shadow register
//   in_valid       in   1         cond_codes valid
//   in_ready       out  1         transaction accepted this cycle if in_valid
//   cond_codes     in   4*LANES   lane i code at [4i+3:4i]
//   out_valid      out  1         cond_out holds a result
//   out_ready      in   1         consumer takes the result
//   cond_out       out  LANES     bit i = result of lane i
//   flags_q        out  4         current architectural flags {Z,N,C,V}
// -----------------------------------------------------------------------------
module cond_eval_unit
   import cond_pkg::*;
#(
   parameter int LANES = 2
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flags_we,
   input  logic [3:0]         flags_wdata,
   input  logic               flags_save,
   input  logic               flags_restore,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [4*LANES-1:0] cond_codes,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LANES-1:0]   cond_out,
   output logic [3:0]         flags_q
);

   flags_t            flags_r;
   flags_t            shadow_r;
   flags_t            eval_flags_s;
   logic              out_valid_r;
   logic [LANES-1:0]  cond_out_r;
   logic [LANES-1:0]  lane_res_s;
   logic              accept_s;

   // Handshake: a free or draining output slot can take a new transaction
   assign in_ready = ~out_valid_r | out_ready;
   assign accept_s = in_valid & in_ready;

`ifdef COND_FLAG_BYPASS_EN
   // Same-cycle forward of the flag write, matching the register priority
   always_comb begin
      eval_flags_s = flags_r;
      if (flags_restore) begin
         eval_flags_s = shadow_r;
      end else if (flags_we) begin
         eval_flags_s = flags_t'(flags_wdata);
      end else begin
         eval_flags_s = flags_r;
      end
   end
`else
   // Lanes see only the committed flags; writes apply to later transactions
   assign eval_flags_s = flags_r;
`endif

   // One evaluator per lane
   generate
      for (genvar g = 0; g < LANES; g++) begin : g_lane
         cond_lane u_lane (
            .code   (cond_codes[4*g +: 4]),
            .flags  (eval_flags_s),
            .result (lane_res_s[g])
         );
      end
   endgenerate

   // Flag and shadow registers; save reads the pre-edge flags so that
   // save+restore swaps and save+we parks the old value
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flags_r  <= 4'h0;
         shadow_r <= 4'h0;
      end else begin
         if (flags_save) begin
            shadow_r <= flags_r;
         end else begin
            shadow_r <= shadow_r;
         end

         if (flags_restore) begin
            flags_r <= shadow_r;
         end else if (flags_we) begin
            flags_r <= flags_t'(flags_wdata);
         end else begin
            flags_r <= flags_r;
         end
      end
   end

   // Output stage: load on accept, clear valid on a bare retire, hold on stall
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         cond_out_r  <= {LANES{1'b0}};
      end else if (accept_s) begin
         out_valid_r <= 1'b1;
         cond_out_r  <= lane_res_s;
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
         cond_out_r  <= cond_out_r;
      end else begin
         out_valid_r <= out_valid_r;
         cond_out_r  <= cond_out_r;
      end
   end

   assign out_valid = out_valid_r;
   assign cond_out  = cond_out_r;
   assign flags_q   = flags_r;

endmodule : cond_eval_unit

// File: tb/tb_cond_eval_unit.sv
module tb_cond_eval_unit;

   localparam int LANES = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             flags_we;
   logic [3:0]       flags_wdata;
   logic             flags_save;
   logic             flags_restore;
   logic             in_valid;
   logic             in_ready;
   logic [4*LANES-1:0] cond_codes;
   logic             out_valid;
   logic             out_ready;
   logic [LANES-1:0] cond_out;
   logic [3:0]       flags_q;

   int errors = 0;
   int checks = 0;

   cond_eval_unit #(.LANES(LANES)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flags_we      (flags_we),
      .flags_wdata   (flags_wdata),
      .flags_save    (flags_save),
      .flags_restore (flags_restore),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .cond_codes    (cond_codes),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .cond_out      (cond_out),
      .flags_q       (flags_q)
   );

   always #5 clk = ~clk;

   // Reference: codes come in true/inverted pairs; even code picks the base test
   function automatic logic ref_cond(input logic [3:0] code, input logic [3:0] f);
      logic z, n, c, v, base;
      z = f[3]; n = f[2]; c = f[1]; v = f[0];
      case (code[3:1])
         3'd0: base = z;
         3'd1: base = c;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = c & ~z;
         3'd5: base = (n == v);
         3'd6: base = ~z & (n == v);
         3'd7: base = 1'b1;
         default: base = 1'b0;
      endcase
      return code[0] ? ~base : base;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flags_we = 1'b0; flags_wdata = 4'h0; flags_save = 1'b0; flags_restore = 1'b0;
      in_valid = 1'b0; cond_codes = '0; out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      in_valid = 1'b1; flags_we = 1'b1; flags_wdata = 4'hF; cond_codes = 8'hEE;
      step(); step();
      rst_n = 1'b1;
      idle_inputs();
      #1;
      checks++; if (flags_q !== 4'h0) begin errors++; $display("FAIL reset_flags_q got=%h exp=0", flags_q); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (cond_out !== 2'b00) begin errors++; $display("FAIL reset_cond_out got=%b exp=00", cond_out); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_all_codes();
      logic [3:0] c0, c1;
      logic [1:0] exp;
      out_ready = 1'b1;
      for (int f = 0; f < 16; f++) begin
         idle_inputs();
         flags_we = 1'b1; flags_wdata = 4'(f);
         step();
         for (int p = 0; p < 8; p++) begin
            c0 = 4'(2 * p); c1 = 4'(2 * p + 1);
            flags_we = 1'b0; in_valid = 1'b1; cond_codes = {c1, c0};
            step();
            exp = {ref_cond(c1, 4'(f)), ref_cond(c0, 4'(f))};
            checks++;
            if (cond_out !== exp || out_valid !== 1'b1) begin
               errors++;
               $display("FAIL codes flags=%h codes=%h got=%b/%b exp=%b/1", f, {c1, c0}, cond_out, out_valid, exp);
            end
         end
      end
      idle_inputs();
      step();
   endtask

   task automatic test_bypass();
      logic [1:0] exp;
      idle_inputs();
      flags_we = 1'b1; flags_wdata = 4'h0;
      step();
      flags_we = 1'b1; flags_wdata = 4'b1000; in_valid = 1'b1; cond_codes = {4'd1, 4'd0};
      step();
`ifdef COND_FLAG_BYPASS_EN
      exp = 2'b01;
`else
      exp = 2'b10;
`endif
      checks++; if (cond_out !== exp) begin errors++; $display("FAIL bypass_cond_out got=%b exp=%b", cond_out, exp); end
      checks++; if (flags_q !== 4'b1000) begin errors++; $display("FAIL bypass_flags_q got=%h exp=8", flags_q); end
      idle_inputs();
      step();
   endtask

   task automatic test_stall();
      idle_inputs();
      flags_we = 1'b1; flags_wdata = 4'h0;
      step();
      flags_we = 1'b0; in_valid = 1'b1; cond_codes = {4'd15, 4'd10};
      step();
      checks++; if (cond_out !== 2'b01 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_accept got=%b/%b exp=01/1", cond_out, out_valid); end
      in_valid = 1'b1; cond_codes = {4'd14, 4'd14}; out_ready = 1'b0;
      flags_we = 1'b1; flags_wdata = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (cond_out !== 2'b01 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold cyc=%0d got=%b/%b/%b exp=01/1/0", i, cond_out, out_valid, in_ready);
         end
      end
      checks++; if (flags_q !== 4'b0100) begin errors++; $display("FAIL stall_flags got=%h exp=4", flags_q); end
      in_valid = 1'b0; flags_we = 1'b0; out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_on_retire got=%b exp=1", in_ready); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_retire got=%b exp=0", out_valid); end
   endtask

   task automatic test_save_restore();
      idle_inputs();
      flags_we = 1'b1; flags_wdata = 4'b0010; step();
      flags_we = 1'b0; flags_save = 1'b1; step();
      flags_save = 1'b0; flags_we = 1'b1; flags_wdata = 4'b1101; step();
      checks++; if (flags_q !== 4'b1101) begin errors++; $display("FAIL sr_write got=%h exp=d", flags_q); end
      flags_we = 1'b0; flags_restore = 1'b1; step();
      checks++; if (flags_q !== 4'b0010) begin errors++; $display("FAIL sr_restore got=%h exp=2", flags_q); end
      flags_restore = 1'b0; flags_we = 1'b1; flags_wdata = 4'b0111; step();
      flags_we = 1'b0; flags_save = 1'b1; flags_restore = 1'b1; step();
      checks++; if (flags_q !== 4'b0010) begin errors++; $display("FAIL sr_swap_flags got=%h exp=2", flags_q); end
      flags_save = 1'b0; flags_restore = 1'b1; step();
      checks++; if (flags_q !== 4'b0111) begin errors++; $display("FAIL sr_swap_shadow got=%h exp=7", flags_q); end
      idle_inputs();
      flags_save = 1'b1; flags_we = 1'b1; flags_wdata = 4'b1001; step();
      flags_save = 1'b0; flags_we = 1'b0; flags_restore = 1'b1; step();
      checks++; if (flags_q !== 4'b0111) begin errors++; $display("FAIL sr_save_we got=%h exp=7", flags_q); end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      logic [7:0] vec [8];
      logic [1:0] exp;
      vec[0] = 8'h10; vec[1] = 8'h32; vec[2] = 8'h54; vec[3] = 8'h76;
      vec[4] = 8'h98; vec[5] = 8'hBA; vec[6] = 8'hDC; vec[7] = 8'hA3;
      idle_inputs();
      flags_we = 1'b1; flags_wdata = 4'b0110; step();
      flags_we = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; cond_codes = vec[i];
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, in_ready); end
         step();
         exp = {ref_cond(vec[i][7:4], 4'b0110), ref_cond(vec[i][3:0], 4'b0110)};
         checks++;
         if (cond_out !== exp || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b i=%0d got=%b/%b exp=%b/1", i, cond_out, out_valid, exp);
         end
      end
      in_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_all_codes();
      test_bypass();
      test_stall();
      test_save_restore();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_cond_eval_unit

// File: doc/cond_eval_unit.md
# cond_eval_unit

Multi-lane condition evaluation unit with its own architectural flag register. It replaces the single combinational condition tester in the data path. It holds the Z N C V flags, updates them from the ALU, and saves/restores them for exception entry/return. It evaluates LANES 4-bit condition codes per transaction behind a valid/ready registered output stage, feeding branch and predicated-execution logic.

## Interface
- LANES, default 2: number of condition codes evaluated per transaction, minimum 1.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flags_we  in  1  load flags_wdata into the flag register (ALU S-bit update).
- flags_wdata  in  4  new flags, bit order {Z,N,C,V}: [3]=Z, [2]=N, [1]=C, [0]=V.
- flags_save  in  1  copy the current flag register into the shadow register.
- flags_restore  in  1  load the flag register from the shadow register.
- in_valid  in  1  cond_codes valid.
- in_ready  out  1  unit accepts a transaction this cycle.
- cond_codes  in  4*LANES  lane i code at [4i+3:4i].
- out_valid  out  1  cond_out holds a result.
- out_ready  in  1  consumer takes the result.
- cond_out  out  LANES  bit i = condition result of lane i.
- flags_q  out  4  current architectural flags {Z,N,C,V}.

## Operation
- Codes: 0 EQ Z; 1 NE !Z; 2 CS/HS C; 3 CC/LO !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0 (defined, never true).
- Flag register priority: flags_restore > flags_we > hold.
- flags_save captures the pre-edge flags_q. With save+we, the shadow gets the old flags and the register gets wdata. With save+restore, the two registers swap.
- Accept: in_valid && in_ready. On accept, every lane is evaluated against the "eval flags" and registered into cond_out, and out_valid is set.
- in_ready = !out_valid || out_ready, combinational, with no dependency on in_valid.
- Output retire: out_valid && out_ready with no new accept clears out_valid. Retire plus a new accept in the same cycle reloads cond_out and keeps out_valid at 1.
- Stall (out_valid && !out_ready): cond_out and out_valid hold stable. Later flag changes do not alter a held result.
- Flag updates proceed independent of the handshake, including during a stall.

## Timing
- Reset (rst_n=0 at an edge) sets flags_q=0, shadow=0, out_valid=0 and cond_out=0. in_ready=1 in the first cycle after reset. All inputs are ignored while rst_n=0.
- Reset mid-transaction discards the held result, with no retire.
- Latency: accept at edge k gives cond_out/out_valid visible after edge k; throughput is 1 per cycle when out_ready=1.
- flags_we/restore written at edge k are visible on flags_q after edge k.
- Eval flags: see Configuration.

## Configuration
- COND_FLAG_BYPASS_EN defined: eval flags use a same-cycle forward.
  - Shadow value if flags_restore.
  - Otherwise flags_wdata if flags_we.
  - Otherwise flags_q.
  - An instruction accepted in the same cycle as the flag-setting write sees the new flags.
- Undefined: eval flags = flags_q only. A same-cycle update is seen by transactions accepted from the next cycle on, and the bypass mux is absent.

## Structure
- Package cond_pkg holds:
  - localparams for the 16 condition codes (COND_EQ … COND_NV);
  - flag bit indices FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0;
  - a 4-bit flags typedef.
- Sub-module cond_lane: purely combinational, 4-bit code plus 4-bit flags gives a 1-bit result. It is instantiated LANES times by generate.
- The top level owns the flag/shadow registers, the bypass mux, the output register and the handshake.

## Test plan
- Reset with rst_n=0 for 2 cycles while in_valid=1 and flags_we=1 (wdata 4'hF) → flags_q=0, out_valid=0, cond_out=0, in_ready=1.
- All 16 codes × all 16 flag values, LANES=2, out_ready=1 → each cond_out matches the code table one cycle after accept. Code 15 always gives 0 and code 14 always gives 1.
- flags_we=1, wdata=4'b1000 (Z) and accept codes {EQ,NE} in the same cycle:
  - with COND_FLAG_BYPASS_EN → cond_out=2'b01 (lane0=EQ=1);
  - without → result uses the old flags 0, giving cond_out=2'b10.
- Stall: accept GE with flags 0 (result 1), hold out_ready=0 for 3 cycles while writing flags 4'b0100 → cond_out stays 1, out_valid stays 1, in_ready=0. Raising out_ready retires it.
- Save/restore: flags 4'b0010, then save, then write 4'b1101, then restore → flags_q=4'b0010. Save+restore in the same cycle swaps flags_q and the shadow.
- Back-to-back accepts with out_ready=1 for 8 cycles and varying codes → one result per cycle, in order, with no bubbles.
